// File: rtl/pcs_tx_block_builder_pkg.sv
// Shared constants and types for the 10GBASE-R transmit block builder.
// Sync headers, block-type bytes and the terminate-type lookup live here.
package pcs_tx_block_builder_pkg;

  localparam int BLOCK_W     = 64;
  localparam int BLOCK_LEN_W = 4;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam logic [7:0] BT_START  = 8'h78;
  localparam logic [7:0] BT_IDLE   = 8'h1E;
  localparam logic [7:0] CTRL_IDLE = 8'h00;
  localparam logic [7:0] CTRL_ERR  = 8'h1E;

  localparam logic [7:0] TERM_TYPE [0:7] = '{
    8'h87, 8'h99, 8'hAA, 8'hB4,
    8'hCC, 8'hD2, 8'hE1, 8'hFF
  };

  typedef enum logic [2:0] {
    BLK_DATA,
    BLK_START,
    BLK_TERM,
    BLK_IDLE,
    BLK_ERR
  } blk_kind_e;

endpackage

// File: rtl/pcs_tx_block_builder_if.sv
// Beat input from eth_tx and block output to the scrambler.
// slave is the block builder side, master is the driver/sink side.
interface pcs_tx_block_builder_if
  import pcs_tx_block_builder_pkg::*;
#(
  parameter int DATA_W = 16
);

  logic                   ctrl_v_i;
  logic [DATA_W-1:0]      data_i;
  logic                   start_i;
  logic                   idle_i;
  logic                   term_i;
  logic [BLOCK_LEN_W-1:0] term_len_i;
  logic                   ready_o;

  logic                   pcs_valid_o;
  logic [1:0]             pcs_head_o;
  logic [BLOCK_W-1:0]     pcs_data_o;
  logic                   pcs_ready_i;
  logic                   err_o;

  modport slave (
    input  ctrl_v_i, data_i, start_i, idle_i,
    input  term_i, term_len_i, pcs_ready_i,
    output ready_o, pcs_valid_o, pcs_head_o,
    output pcs_data_o, err_o
  );

  modport master (
    output ctrl_v_i, data_i, start_i, idle_i,
    output term_i, term_len_i, pcs_ready_i,
    input  ready_o, pcs_valid_o, pcs_head_o,
    input  pcs_data_o, err_o
  );

endinterface

// File: rtl/pcs_tx_block_builder_term_shift.sv
// Terminate block payload: type byte from length, data bytes moved up
// by one lane, everything past the last data byte filled with /I/.
module pcs_tx_block_builder_term_shift
  import pcs_tx_block_builder_pkg::*;
(
  input  logic [BLOCK_W-1:0] bytes,
  input  logic [2:0]         len,
  output logic [BLOCK_W-1:0] block
);

  logic [BLOCK_W-1:0] shifted;

  always_comb begin
    shifted = {bytes[BLOCK_W-9:0], 8'h00};
    block   = '0;
    block[7:0] = TERM_TYPE[len];
    for (int i = 1; i < 8; i++) begin
      if (len >= 3'(i)) begin
        block[i*8 +: 8] = shifted[i*8 +: 8];
      end else begin
        block[i*8 +: 8] = CTRL_IDLE;
      end
    end
  end

endmodule

// File: rtl/pcs_tx_block_builder.sv
// Packs eth_tx beats into 64-bit 10GBASE-R blocks with sync header
// and block-type byte, with a one-deep output register to the scrambler.
module pcs_tx_block_builder
  import pcs_tx_block_builder_pkg::*;
#(
  parameter int DATA_W = 16
)(
  input  logic                  clk,
  input  logic                  nreset,
  pcs_tx_block_builder_if.slave bus
);

  localparam int BEAT_N = BLOCK_W / DATA_W;
  localparam int CNT_W  = $clog2(BEAT_N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEAT_N - 1);

  logic [CNT_W-1:0]   beat_cnt;
  blk_kind_e          kind_q;
  blk_kind_e          kind_in;
  logic [2:0]         len_q;
  logic [BLOCK_W-1:0] asm_q;
  logic [BLOCK_W-1:0] asm_nx;
  logic [BLOCK_W-1:0] term_blk;
  logic [BLOCK_W-1:0] blk_nx;
  logic [1:0]         head_nx;
  logic               valid_q;
  logic [1:0]         head_q;
  logic [BLOCK_W-1:0] data_q;
  logic               err_q;
  logic               accept;
  logic               last;
  logic               lane0;

  assign last   = beat_cnt == LAST;
  assign lane0  = beat_cnt == '0;
  assign accept = !last || !valid_q || bus.pcs_ready_i;

  assign bus.ready_o     = accept;
  assign bus.pcs_valid_o = valid_q;
  assign bus.pcs_head_o  = head_q;
  assign bus.pcs_data_o  = data_q;
  assign bus.err_o       = err_q;

  always_comb begin
    kind_in = BLK_DATA;
    if (bus.ctrl_v_i) begin
      unique case ({bus.start_i, bus.idle_i, bus.term_i})
        3'b100:  kind_in = BLK_START;
        3'b010:  kind_in = BLK_IDLE;
        3'b001:  kind_in = (bus.term_len_i > 4'd7) ? BLK_ERR : BLK_TERM;
        default: kind_in = BLK_ERR;
      endcase
    end
  end

  always_comb begin
    asm_nx = asm_q;
    asm_nx[beat_cnt*DATA_W +: DATA_W] = bus.data_i;
  end

  pcs_tx_block_builder_term_shift u_term_shift (
    .bytes (asm_nx),
    .len   (len_q),
    .block (term_blk)
  );

  always_comb begin
    head_nx = SYNC_CTRL;
    blk_nx  = {8{CTRL_ERR}};
    unique case (kind_q)
      BLK_DATA: begin
        head_nx = SYNC_DATA;
        blk_nx  = asm_nx;
      end
      BLK_START: blk_nx = {asm_nx[BLOCK_W-1:8], BT_START};
      BLK_TERM:  blk_nx = term_blk;
      BLK_IDLE:  blk_nx = {{7{CTRL_IDLE}}, BT_IDLE};
      default:   blk_nx = {8{CTRL_ERR}};
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      beat_cnt <= '0;
      kind_q   <= BLK_DATA;
      len_q    <= '0;
      asm_q    <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        beat_cnt <= last ? '0 : beat_cnt + CNT_W'(1);
        asm_q    <= asm_nx;
        if (lane0) begin
          kind_q <= kind_in;
          len_q  <= bus.term_len_i[2:0];
          if (kind_in == BLK_ERR) err_q <= 1'b1;
        end
      end
      // a load in the same cycle as a drain keeps valid high
      if (accept && last) begin
        valid_q <= 1'b1;
        head_q  <= head_nx;
        data_q  <= blk_nx;
      end else if (bus.pcs_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pcs_tx_block_builder.sv
// Directed bench for pcs_tx_block_builder: continuous beat stream,
// captured blocks compared in order against hand-computed blocks.
module tb_pcs_tx_block_builder;

  logic clk;
  logic nreset;

  pcs_tx_block_builder_if #(.DATA_W(16)) bus ();

  pcs_tx_block_builder #(.DATA_W(16)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lane0_cyc = 0;
  int first_lane0 = 0;
  logic ready_low_seen = 1'b0;

  logic [1:0]  exp_h [$];
  logic [63:0] exp_d [$];
  logic [1:0]  cap_h [$];
  logic [63:0] cap_d [$];
  int          cap_c [$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (nreset && !bus.ready_o) ready_low_seen = 1'b1;
    if (nreset && bus.pcs_valid_o && bus.pcs_ready_i) begin
      cap_h.push_back(bus.pcs_head_o);
      cap_d.push_back(bus.pcs_data_o);
      cap_c.push_back(cyc);
    end
  end

  task automatic expect_blk(input logic [1:0] h, input logic [63:0] d);
    exp_h.push_back(h);
    exp_d.push_back(d);
  endtask

  // later beats carry junk qualifiers, which must be ignored
  task automatic send_block(input logic cv, input logic st,
                            input logic id, input logic tm,
                            input logic [3:0] len,
                            input logic [63:0] d, input int nb);
    int waited;
    for (int b = 0; b < nb; b++) begin
      bus.ctrl_v_i   = (b == 0) ? cv : 1'b1;
      bus.start_i    = (b == 0) ? st : 1'b1;
      bus.idle_i     = (b == 0) ? id : 1'b0;
      bus.term_i     = (b == 0) ? tm : 1'b1;
      bus.term_len_i = (b == 0) ? len : 4'hF;
      bus.data_i     = d[b*16 +: 16];
      waited = 0;
      @(negedge clk);
      while (!bus.ready_o && waited < 50) begin
        waited++;
        @(negedge clk);
      end
      if (waited >= 50) chk("ready_timeout", 64'd0, 64'd1);
      if (b == 0) lane0_cyc = cyc;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int guard;
    nreset          = 1'b0;
    bus.ctrl_v_i    = 1'b0;
    bus.data_i      = '0;
    bus.start_i     = 1'b0;
    bus.idle_i      = 1'b0;
    bus.term_i      = 1'b0;
    bus.term_len_i  = '0;
    bus.pcs_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(bus.pcs_valid_o), 64'd0);
    chk("rst_err", 64'(bus.err_o), 64'd0);
    chk("rst_ready", 64'(bus.ready_o), 64'd1);
    @(posedge clk);
    #1 nreset = 1'b1;

    send_block(0, 0, 0, 0, 4'd0, 64'h7766554433221100, 4);
    first_lane0 = lane0_cyc;
    expect_blk(2'b01, 64'h7766554433221100);
    send_block(1, 1, 0, 0, 4'd0, 64'hD555555555555555, 4);
    expect_blk(2'b10, 64'hD555555555555578);
    send_block(1, 0, 0, 1, 4'd3, 64'h2211FFEEDDCCBBAA, 4);
    expect_blk(2'b10, 64'h00000000CCBBAAB4);
    send_block(1, 0, 0, 1, 4'd0, 64'h2211FFEEDDCCBBAA, 4);
    expect_blk(2'b10, 64'h0000000000000087);
    send_block(1, 0, 0, 1, 4'd7, 64'h2211FFEEDDCCBBAA, 4);
    expect_blk(2'b10, 64'h11FFEEDDCCBBAAFF);
    send_block(1, 0, 1, 0, 4'd0, 64'hFFFFFFFFFFFFFFFF, 4);
    expect_blk(2'b10, 64'h000000000000001E);
    send_block(1, 0, 1, 0, 4'd0, 64'h0123012301230123, 4);
    expect_blk(2'b10, 64'h000000000000001E);

    fork
      begin
        send_block(0, 0, 0, 0, 4'd0, 64'h0807060504030201, 4);
        send_block(0, 0, 0, 0, 4'd0, 64'h1817161514131211, 4);
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus.pcs_ready_i = 1'b0;
        repeat (6) @(posedge clk);
        #1 bus.pcs_ready_i = 1'b1;
      end
    join
    expect_blk(2'b01, 64'h0807060504030201);
    expect_blk(2'b01, 64'h1817161514131211);
    chk("stall_ready_low", 64'(ready_low_seen), 64'd1);
    chk("err_before", 64'(bus.err_o), 64'd0);

    send_block(1, 1, 0, 1, 4'd0, 64'h1111111111111111, 4);
    expect_blk(2'b10, 64'h1E1E1E1E1E1E1E1E);
    chk("err_set", 64'(bus.err_o), 64'd1);
    send_block(1, 0, 0, 1, 4'd8, 64'h2222222222222222, 4);
    expect_blk(2'b10, 64'h1E1E1E1E1E1E1E1E);

    send_block(0, 0, 0, 0, 4'd0, 64'hAAAAAAAAAAAAAAAA, 2);
    nreset = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 64'(bus.pcs_valid_o), 64'd0);
    chk("midrst_err", 64'(bus.err_o), 64'd0);
    chk("midrst_ready", 64'(bus.ready_o), 64'd1);
    @(posedge clk);
    #1 nreset = 1'b1;
    send_block(0, 0, 0, 0, 4'd0, 64'h0123456789ABCDEF, 4);
    expect_blk(2'b01, 64'h0123456789ABCDEF);

    bus.ctrl_v_i = 1'b0;
    bus.start_i  = 1'b0;
    bus.term_i   = 1'b0;
    bus.data_i   = '0;
    guard = 0;
    while (cap_h.size() < exp_h.size() && guard < 300) begin
      guard++;
      @(negedge clk);
    end
    chk("blk_count_ok",
        64'(cap_h.size() >= exp_h.size()), 64'd1);
    for (int i = 0; i < exp_h.size(); i++) begin
      if (i < cap_h.size()) begin
        chk($sformatf("blk%0d_head", i), 64'(cap_h[i]), 64'(exp_h[i]));
        chk($sformatf("blk%0d_data", i), cap_d[i], exp_d[i]);
      end
    end
    if (cap_c.size() > 6) begin
      chk("latency", 64'(cap_c[0] - first_lane0), 64'd4);
      chk("idle_spacing", 64'(cap_c[6] - cap_c[5]), 64'd4);
    end else begin
      chk("timing_caps", 64'(cap_c.size()), 64'd7);
    end
    chk("err_after_rst", 64'(bus.err_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
